computational_unit_p: RTL and testbench

- Parametrised successor of the 4-bit computational unit: the datapath width is a parameter.
- Holds the same register file: x0, x1, y0, y1, r, m, i, o_reg.
- Adds synchronous reset of all state, a carry flag, and an iterative shift-add multiplier with a busy handshake.
- Sits between the instruction decoder/program sequencer and data memory. It drives the shared data bus and feeds {x1,x0} back to the sequencer.

---
 rtl/computational_unit_p_if.sv | 44 ++++
 rtl/computational_unit_p.sv | 237 +++++++++++++++++++++++
 tb/tb_computational_unit_p.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/computational_unit_p_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | computational_unit_p_if: control/data bundle between sequencer,        |
// | data memory and the computational unit.   Rev 1.0                      |
// +------------------------------------------------------------------------+
interface computational_unit_p_if #(
    parameter int DW = 4
);
    logic [DW-1:0]   dm;
    logic [DW-1:0]   ir_operand;
    logic            i_sel;
    logic            x_sel;
    logic            y_sel;
    logic [3:0]      source_sel;
    logic [8:0]      reg_en;
    logic [DW-1:0]   i_pins;

    logic [DW-1:0]   x0;
    logic [DW-1:0]   x1;
    logic [DW-1:0]   y0;
    logic [DW-1:0]   y1;
    logic [DW-1:0]   r;
    logic [DW-1:0]   m;
    logic [DW-1:0]   i;
    logic [DW-1:0]   o_reg;
    logic [DW-1:0]   data_bus;
    logic            r_eq_0;
    logic            r_carry;
    logic            alu_busy;
    logic [2*DW-1:0] from_cu;

    modport master (
        output dm, ir_operand, i_sel, x_sel, y_sel, source_sel, reg_en, i_pins,
        input  x0, x1, y0, y1, r, m, i, o_reg, data_bus,
               r_eq_0, r_carry, alu_busy, from_cu
    );

    modport slave (
        input  dm, ir_operand, i_sel, x_sel, y_sel, source_sel, reg_en, i_pins,
        output x0, x1, y0, y1, r, m, i, o_reg, data_bus,
               r_eq_0, r_carry, alu_busy, from_cu
    );
endinterface
`default_nettype wire

// File: rtl/computational_unit_p.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | computational_unit_p: parametrised register file, ALU and shift-add    |
// | multiplier. Macro CU_FAST_MULT_EN selects a single-cycle multiplier.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module computational_unit_p #(
    parameter int DW        = 4,
    parameter int MUL_CNT_W = 3
) (
    input  wire logic             clk,
    input  wire logic             sync_reset,
    computational_unit_p_if.slave bus_if
);
    localparam int PW = 2 * DW;

    logic [DW-1:0] x0_q, x1_q, y0_q, y1_q, m_q, i_q, o_reg_q;
    logic [DW-1:0] r_q, r_d;
    logic          eq_q, eq_d;
    logic          carry_q, carry_d;

    logic [DW-1:0] w_bus, w_x, w_y, w_alu_res;
    logic [2:0]    w_f;
    logic          w_ir3, w_alu_we, w_alu_cwe, w_alu_carry, w_idle;
    logic          w_unused;

    assign w_f      = bus_if.ir_operand[2:0];
    assign w_ir3    = bus_if.ir_operand[3];
    assign w_x      = bus_if.x_sel ? x1_q : x0_q;
    assign w_y      = bus_if.y_sel ? y1_q : y0_q;
    assign w_unused = ^{bus_if.reg_en[7], bus_if.ir_operand};

    always_comb begin
        w_bus = '0;
        case (bus_if.source_sel)
            4'd0:    w_bus = x0_q;
            4'd1:    w_bus = x1_q;
            4'd2:    w_bus = y0_q;
            4'd3:    w_bus = y1_q;
            4'd4:    w_bus = r_q;
            4'd5:    w_bus = m_q;
            4'd6:    w_bus = i_q;
            4'd7:    w_bus = bus_if.dm;
            4'd8:    w_bus = bus_if.ir_operand;
            4'd9:    w_bus = bus_if.i_pins;
            default: w_bus = '0;
        endcase
    end

`ifdef CU_FAST_MULT_EN
    logic [PW-1:0] w_prod;
    assign w_prod = {{DW{1'b0}}, w_x} * {{DW{1'b0}}, w_y};
`else
    logic          w_mul_req;
`endif

    always_comb begin
        w_alu_res   = '0;
        w_alu_we    = 1'b0;
        w_alu_cwe   = 1'b0;
        w_alu_carry = 1'b0;
`ifndef CU_FAST_MULT_EN
        w_mul_req   = 1'b0;
`endif
        case (w_f)
            3'b000: begin
                w_alu_we  = !w_ir3;
                w_alu_res = -w_x;
            end
            3'b001: begin
                w_alu_we  = 1'b1;
                w_alu_cwe = 1'b1;
                {w_alu_carry, w_alu_res} = {1'b0, w_x} - {1'b0, w_y};
            end
            3'b010: begin
                w_alu_we  = 1'b1;
                w_alu_cwe = 1'b1;
                {w_alu_carry, w_alu_res} = {1'b0, w_x} + {1'b0, w_y};
            end
            3'b011, 3'b100: begin
`ifdef CU_FAST_MULT_EN
                w_alu_we  = 1'b1;
                w_alu_res = (w_f == 3'b011) ? w_prod[PW-1:DW] : w_prod[DW-1:0];
`else
                w_mul_req = 1'b1;
`endif
            end
            3'b101: begin
                w_alu_we  = 1'b1;
                w_alu_res = w_x ^ w_y;
            end
            3'b110: begin
                w_alu_we  = 1'b1;
                w_alu_res = w_x & w_y;
            end
            default: begin
                w_alu_we  = !w_ir3;
                w_alu_res = ~w_x;
            end
        endcase
    end

`ifdef CU_FAST_MULT_EN
    assign w_idle          = 1'b1;
    assign bus_if.alu_busy = 1'b0;

    always_comb begin
        r_d     = r_q;
        eq_d    = eq_q;
        carry_d = carry_q;
        if (bus_if.reg_en[4] && w_idle && w_alu_we) begin
            r_d  = w_alu_res;
            eq_d = (w_alu_res == '0);
            if (w_alu_cwe) carry_d = w_alu_carry;
        end
    end
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [MUL_CNT_W-1:0] C_CNT_LAST = MUL_CNT_W'(DW - 1);

    state_t               state_q, state_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]        acc_q, acc_d, mcand_q, mcand_d;
    logic [DW-1:0]        mplier_q, mplier_d;
    logic                 hi_q, hi_d;
    logic [PW-1:0]        w_acc_step;
    logic [DW-1:0]        w_mul_res;

    assign w_idle          = (state_q == S_IDLE);
    assign bus_if.alu_busy = (state_q == S_BUSY);
    assign w_acc_step      = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign w_mul_res       = hi_q ? w_acc_step[PW-1:DW] : w_acc_step[DW-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        hi_d     = hi_q;
        r_d      = r_q;
        eq_d     = eq_q;
        carry_d  = carry_q;
        case (state_q)
            S_IDLE: begin
                if (bus_if.reg_en[4] && w_mul_req) begin
                    state_d  = S_BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{DW{1'b0}}, w_x};
                    mplier_d = w_y;
                    hi_d     = (w_f == 3'b011);
                end else if (bus_if.reg_en[4] && w_alu_we) begin
                    r_d  = w_alu_res;
                    eq_d = (w_alu_res == '0);
                    if (w_alu_cwe) carry_d = w_alu_carry;
                end
            end
            S_BUSY: begin
                // Operands live in private registers, so x/y writes cannot disturb the product.
                acc_d    = w_acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + MUL_CNT_W'(1);
                if (cnt_q == C_CNT_LAST) begin
                    state_d = S_IDLE;
                    r_d     = w_mul_res;
                    eq_d    = (w_mul_res == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            hi_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            hi_q     <= hi_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            m_q     <= '0;
            i_q     <= '0;
            o_reg_q <= '0;
            r_q     <= '0;
            eq_q    <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            if (bus_if.reg_en[0]) x0_q    <= w_bus;
            if (bus_if.reg_en[1]) x1_q    <= w_bus;
            if (bus_if.reg_en[2]) y0_q    <= w_bus;
            if (bus_if.reg_en[3]) y1_q    <= w_bus;
            if (bus_if.reg_en[5]) m_q     <= w_bus;
            if (bus_if.reg_en[6]) i_q     <= bus_if.i_sel ? i_q + m_q : w_bus;
            if (bus_if.reg_en[8]) o_reg_q <= w_bus;
            r_q     <= r_d;
            eq_q    <= eq_d;
            carry_q <= carry_d;
        end
    end

    assign bus_if.x0       = x0_q;
    assign bus_if.x1       = x1_q;
    assign bus_if.y0       = y0_q;
    assign bus_if.y1       = y1_q;
    assign bus_if.r        = r_q;
    assign bus_if.m        = m_q;
    assign bus_if.i        = i_q;
    assign bus_if.o_reg    = o_reg_q;
    assign bus_if.data_bus = w_bus;
    assign bus_if.r_eq_0   = eq_q;
    assign bus_if.r_carry  = carry_q;
    assign bus_if.from_cu  = {x1_q, x0_q};
endmodule
`default_nettype wire

// File: tb/tb_computational_unit_p.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_computational_unit_p: directed and random stimulus against an       |
// | arithmetic reference model of the computational unit.   Rev 1.0        |
// +------------------------------------------------------------------------+
module tb_computational_unit_p;
    localparam int DW   = 4;
    localparam int MOD  = 1 << DW;
    localparam int MASK = MOD - 1;
`ifdef CU_FAST_MULT_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = DW;
`endif

    logic clk        = 1'b0;
    logic sync_reset = 1'b0;
    int   n_checks   = 0;
    int   n_pass     = 0;

    computational_unit_p_if #(.DW(DW)) cu_if ();

    computational_unit_p #(.DW(DW), .MUL_CNT_W(3)) u_dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus_if     (cu_if.slave)
    );

    always #5 clk = ~clk;

    // Model state: index 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 o_reg
    int m_reg [8];
    int m_eq, m_carry, m_busy_left, m_pend;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int model_bus();
        int s;
        s = int'(cu_if.source_sel);
        if (s <= 6) return m_reg[s];
        case (s)
            7:       return int'(cu_if.dm);
            8:       return int'(cu_if.ir_operand);
            9:       return int'(cu_if.i_pins);
            default: return 0;
        endcase
    endfunction

    task automatic model_commit(input int v);
        m_reg[4] = v & MASK;
        m_eq     = ((v & MASK) == 0);
    endtask

    task automatic model_edge();
        int bus, xv, yv, f, ir3, s, half;
        bus = model_bus();
        if (sync_reset) begin
            foreach (m_reg[k]) m_reg[k] = 0;
            m_eq = 0; m_carry = 0; m_busy_left = 0; m_pend = 0;
            return;
        end
        xv  = cu_if.x_sel ? m_reg[1] : m_reg[0];
        yv  = cu_if.y_sel ? m_reg[3] : m_reg[2];
        f   = int'(cu_if.ir_operand) & 7;
        ir3 = (int'(cu_if.ir_operand) >> 3) & 1;
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) model_commit(m_pend);
        end else if (cu_if.reg_en[4]) begin
            case (f)
                0: if (ir3 == 0) model_commit(-xv);
                1: begin model_commit(xv - yv); m_carry = (xv < yv); end
                2: begin s = xv + yv; model_commit(s); m_carry = (s > MASK); end
                3, 4: begin
                    half = (f == 3) ? (xv * yv) / MOD : (xv * yv) % MOD;
                    if (MUL_LAT == 0) model_commit(half);
                    else begin m_busy_left = MUL_LAT; m_pend = half; end
                end
                5: model_commit(xv ^ yv);
                6: model_commit(xv & yv);
                default: if (ir3 == 0) model_commit(~xv);
            endcase
        end
        if (cu_if.reg_en[6]) m_reg[6] = cu_if.i_sel ? (m_reg[6] + m_reg[5]) & MASK : bus;
        if (cu_if.reg_en[0]) m_reg[0] = bus;
        if (cu_if.reg_en[1]) m_reg[1] = bus;
        if (cu_if.reg_en[2]) m_reg[2] = bus;
        if (cu_if.reg_en[3]) m_reg[3] = bus;
        if (cu_if.reg_en[5]) m_reg[5] = bus;
        if (cu_if.reg_en[8]) m_reg[7] = bus;
    endtask

    task automatic check_state();
        check("x0", cu_if.x0, m_reg[0]);
        check("x1", cu_if.x1, m_reg[1]);
        check("y0", cu_if.y0, m_reg[2]);
        check("y1", cu_if.y1, m_reg[3]);
        check("r", cu_if.r, m_reg[4]);
        check("m", cu_if.m, m_reg[5]);
        check("i", cu_if.i, m_reg[6]);
        check("o_reg", cu_if.o_reg, m_reg[7]);
        check("r_eq_0", cu_if.r_eq_0, m_eq);
        check("r_carry", cu_if.r_carry, m_carry);
        check("alu_busy", cu_if.alu_busy, int'(m_busy_left > 0));
        check("from_cu", cu_if.from_cu, m_reg[1] * MOD + m_reg[0]);
    endtask

    task automatic tick();
        #1;
        check("data_bus", cu_if.data_bus, model_bus());
        @(posedge clk);
        model_edge();
        #1;
        check_state();
    endtask

    task automatic cyc(input int src, input int en, input int opnd,
                       input bit xs = 1'b0, input bit ys = 1'b0,
                       input bit isel = 1'b0, input bit rst = 1'b0);
        cu_if.source_sel = 4'(src);
        cu_if.reg_en     = 9'(en);
        cu_if.ir_operand = 4'(opnd);
        cu_if.x_sel      = xs;
        cu_if.y_sel      = ys;
        cu_if.i_sel      = isel;
        sync_reset       = rst;
        tick();
    endtask

    initial begin
        cu_if.dm = '0; cu_if.i_pins = '0; cu_if.ir_operand = '0;
        cu_if.source_sel = '0; cu_if.reg_en = '0;
        cu_if.x_sel = 1'b0; cu_if.y_sel = 1'b0; cu_if.i_sel = 1'b0;
        sync_reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        check_state();

        // Reset clears loaded state
        cyc(8, 'h16F, 5);
        cyc(0, 0, 0, .rst(1'b1));
        check("rst_x0", cu_if.x0, 0);
        check("rst_o_reg", cu_if.o_reg, 0);
        check("rst_bus", cu_if.data_bus, 0);

        // Add with carry
        cyc(8, 'h001, 9); cyc(8, 'h004, 9); cyc(0, 'h010, 2);
        check("add1_r", cu_if.r, 2); check("add1_c", cu_if.r_carry, 1); check("add1_z", cu_if.r_eq_0, 0);
        cyc(8, 'h001, 1); cyc(8, 'h004, 15); cyc(0, 'h010, 2);
        check("add2_r", cu_if.r, 0); check("add2_c", cu_if.r_carry, 1); check("add2_z", cu_if.r_eq_0, 1);

        // Negate, not, then no-op holds r and flags
        cyc(8, 'h002, 0); cyc(0, 'h010, 0, .xs(1'b1));
        check("neg_r", cu_if.r, 0); check("neg_z", cu_if.r_eq_0, 1);
        cyc(8, 'h001, 15); cyc(0, 'h010, 7);
        check("not_r", cu_if.r, 0); check("not_z", cu_if.r_eq_0, 1);
        cyc(0, 'h010, 2);
        check("add3_r", cu_if.r, 14);
        cyc(0, 'h010, 8);
        check("nop_r", cu_if.r, 14); check("nop_c", cu_if.r_carry, 1); check("nop_z", cu_if.r_eq_0, 0);
        cyc(0, 'h010, 15);
        check("nop7_r", cu_if.r, 14);

        // Multiply high, then low with x0 overwrite and ignored request in flight
        cyc(8, 'h001, 7); cyc(8, 'h004, 3); cyc(0, 'h010, 3);
        check("mul_busy", cu_if.alu_busy, int'(MUL_LAT > 0));
        for (int k = 0; k < MUL_LAT; k++) cyc(0, 0, 0);
        check("mul_hi", cu_if.r, 1);
        check("mul_idle", cu_if.alu_busy, 0);
        cyc(0, 'h010, 4);
        for (int k = 0; k < MUL_LAT; k++) begin
            case (k)
                0:       cyc(8, 'h001, 0);
                1:       cyc(0, 'h010, 2);
                default: cyc(0, 0, 0);
            endcase
        end
        check("mul_lo", cu_if.r, 5);

        // Reset during the second busy cycle aborts the product
        cyc(8, 'h001, 7); cyc(0, 'h010, 4); cyc(0, 0, 0);
        cyc(0, 0, 0, .rst(1'b1));
        check("abort_busy", cu_if.alu_busy, 0);
        check("abort_r", cu_if.r, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0);
        check("abort_r_late", cu_if.r, 0);

        // Index register wraps modulo 2**DW
        cyc(8, 'h020, 3); cyc(8, 'h040, 14);
        cyc(0, 'h040, 0, .isel(1'b1)); check("idx1", cu_if.i, 1);
        cyc(0, 'h040, 0, .isel(1'b1)); check("idx2", cu_if.i, 4);
        cyc(0, 'h040, 0, .isel(1'b1)); check("idx3", cu_if.i, 7);

        // Every bus source
        cu_if.dm = 4'(10); cu_if.i_pins = 4'(6);
        for (int s = 0; s < 16; s++) begin
            cyc(s, 0, 11);
            if (s >= 10) check("bus_hi", cu_if.data_bus, 0);
        end

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            cu_if.dm     = 4'($urandom);
            cu_if.i_pins = 4'($urandom);
            cyc(int'($urandom_range(0, 15)), int'($urandom_range(0, 511)),
                int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                1'($urandom), ($urandom_range(0, 49) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
